// File: rtl/riscv_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : riscv_pkg
//  Description : RV32I decode definitions shared by the decode stage:
//                opcode constants, instruction-format enum, the decoded
//                bundle struct and the opcode classifier.
//                Config macro: DECODE_ILLEGAL_TRAP_EN adds an illegal flag
//                to the bundle.
//  Revision    : 1.0 - initial release
// ============================================================================
package riscv_pkg;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;

    typedef enum logic [2:0] {
        TYPE_R       = 3'd0,
        TYPE_I       = 3'd1,
        TYPE_S       = 3'd2,
        TYPE_B       = 3'd3,
        TYPE_U       = 3'd4,
        TYPE_J       = 3'd5,
        TYPE_ILLEGAL = 3'd7
    } instr_type_e;

    typedef struct packed {
        logic [6:0]  opcode;
        logic [4:0]  rd;
        logic [2:0]  funct3;
        logic [4:0]  rs1_addr;
        logic [4:0]  rs2_addr;
        logic [6:0]  funct7;
        logic [31:0] imm;
        instr_type_e instr_type;
        logic [31:0] pc;
        logic [31:0] rs1_data;
        logic [31:0] rs2_data;
`ifdef DECODE_ILLEGAL_TRAP_EN
        logic        illegal;
`endif
    } decoded_t;

    function automatic instr_type_e classify(input logic [6:0] opc);
        instr_type_e t;
        case (opc)
            OPC_OP:                       t = TYPE_R;
            OPC_OP_IMM, OPC_LOAD, OPC_JALR: t = TYPE_I;
            OPC_STORE:                    t = TYPE_S;
            OPC_BRANCH:                   t = TYPE_B;
            OPC_LUI, OPC_AUIPC:           t = TYPE_U;
            OPC_JAL:                      t = TYPE_J;
            default:                      t = TYPE_ILLEGAL;
        endcase
        return t;
    endfunction

endpackage
`default_nettype wire

// File: rtl/imm_gen.sv
`default_nettype none
// ============================================================================
//  Module      : imm_gen
//  Description : Combinational RV32I immediate builder. Produces the
//                sign-extended immediate for the given instruction format;
//                R and ILLEGAL formats yield zero.
//  Ports       : instr      in  [31:7] instruction bits above the opcode
//                instr_type in  format class from the opcode classifier
//                imm        out 32-bit immediate
//  Revision    : 1.0 - initial release
// ============================================================================
module imm_gen
    import riscv_pkg::*;
(
    input  logic [31:7]  instr,
    input  instr_type_e  instr_type,
    output logic [31:0]  imm
);

    always_comb begin
        imm = '0;
        case (instr_type)
            TYPE_I:  imm = {{20{instr[31]}}, instr[31:20]};
            TYPE_S:  imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            TYPE_B:  imm = {{19{instr[31]}}, instr[31], instr[7], instr[30:25],
                            instr[11:8], 1'b0};
            TYPE_U:  imm = {instr[31:12], 12'b0};
            TYPE_J:  imm = {{11{instr[31]}}, instr[31], instr[19:12], instr[20],
                            instr[30:21], 1'b0};
            default: imm = '0;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/instr_decode_stage.sv
`default_nettype none
// ============================================================================
//  Module      : instr_decode_stage
//  Description : RV32I decode stage. Accepts instr/pc from fetch over
//                valid/ready, decodes fields and immediate, reads rs1/rs2
//                from the register file and presents a registered bundle to
//                execute. A one-entry skid buffer lets if_ready come straight
//                from a flop. flush discards everything held or arriving.
//                Config macro: DECODE_ILLEGAL_TRAP_EN adds ex_illegal and
//                zeroes the operand fields of illegal words.
//  Ports       : clk, rst                 clock, sync active-high reset
//                if_valid/if_ready        fetch handshake
//                if_instr/if_pc           fetched word and its pc
//                rf_rs*_addr/rf_rs*_data  combinational register-file read
//                flush                    discard request from execute
//                ex_valid/ex_ready        execute handshake
//                opcode..rs2_data         registered ALU bundle
//                ex_illegal               (macro only) illegal-opcode flag
//  Revision    : 1.0 - initial release
// ============================================================================
module instr_decode_stage
    import riscv_pkg::*;
#(
    parameter int XLEN         = 32,
    parameter int SKID_ENTRIES = 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            if_valid,
    output logic            if_ready,
    input  logic [31:0]     if_instr,
    input  logic [XLEN-1:0] if_pc,
    output logic [4:0]      rf_rs1_addr,
    output logic [4:0]      rf_rs2_addr,
    input  logic [XLEN-1:0] rf_rs1_data,
    input  logic [XLEN-1:0] rf_rs2_data,
    input  logic            flush,
    output logic            ex_valid,
    input  logic            ex_ready,
    output logic [6:0]      opcode,
    output logic [4:0]      rd,
    output logic [2:0]      funct3,
    output logic [4:0]      rs1_addr,
    output logic [4:0]      rs2_addr,
    output logic [6:0]      funct7,
    output logic [XLEN-1:0] imm,
    output logic [2:0]      instr_type,
    output logic [XLEN-1:0] pc,
    output logic [XLEN-1:0] rs1_data,
    output logic [XLEN-1:0] rs2_data
`ifdef DECODE_ILLEGAL_TRAP_EN
    ,
    output logic            ex_illegal
`endif
);

    if (XLEN != 32 || SKID_ENTRIES != 1) begin : g_bad_config
        $error("instr_decode_stage supports only XLEN=32 and SKID_ENTRIES=1");
    end

    instr_type_e w_type;
    logic [31:0] w_imm;
    logic [4:0]  w_rs1_addr;
    logic [4:0]  w_rs2_addr;
    decoded_t    w_dec;

    decoded_t    r_out;
    decoded_t    r_skid;
    logic        r_ex_valid;
    logic        r_skid_valid;
    logic        r_if_ready;

    logic        w_accept;
    logic        w_out_free;
    logic        w_skid_valid_next;

    assign w_type = classify(if_instr[6:0]);

    imm_gen u_imm_gen (
        .instr      (if_instr[31:7]),
        .instr_type (w_type),
        .imm        (w_imm)
    );

    // Unused source registers are forced to x0 so the register file reads 0.
    always_comb begin
        w_rs1_addr = if_instr[19:15];
        w_rs2_addr = if_instr[24:20];
        if (w_type == TYPE_U || w_type == TYPE_J) begin
            w_rs1_addr = 5'd0;
        end
        if (w_type == TYPE_I || w_type == TYPE_U || w_type == TYPE_J) begin
            w_rs2_addr = 5'd0;
        end
    end

    assign rf_rs1_addr = w_rs1_addr;
    assign rf_rs2_addr = w_rs2_addr;

    always_comb begin
        w_dec            = '0;
        w_dec.opcode     = if_instr[6:0];
        w_dec.rd         = (w_type == TYPE_S || w_type == TYPE_B) ? 5'd0 : if_instr[11:7];
        w_dec.funct3     = if_instr[14:12];
        w_dec.rs1_addr   = w_rs1_addr;
        w_dec.rs2_addr   = w_rs2_addr;
        w_dec.funct7     = if_instr[31:25];
        w_dec.imm        = w_imm;
        w_dec.instr_type = w_type;
        w_dec.pc         = if_pc;
        w_dec.rs1_data   = rf_rs1_data;
        w_dec.rs2_data   = rf_rs2_data;
`ifdef DECODE_ILLEGAL_TRAP_EN
        // Zeroed operand fields make the ALU see a NOP for a trapped word.
        if (w_type == TYPE_ILLEGAL) begin
            w_dec.illegal  = 1'b1;
            w_dec.opcode   = '0;
            w_dec.rd       = '0;
            w_dec.rs1_addr = '0;
            w_dec.rs2_addr = '0;
            w_dec.imm      = '0;
            w_dec.rs1_data = '0;
            w_dec.rs2_data = '0;
        end
`endif
    end

    assign w_accept   = if_valid & r_if_ready;
    assign w_out_free = ~r_ex_valid | ex_ready;

    // The skid only fills while the output is stalled. When the output frees
    // up the skid always drains; if_ready was low while it was full, so no
    // new word can compete for the output in that cycle.
    assign w_skid_valid_next = w_out_free ? 1'b0 : (r_skid_valid | w_accept);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_out        <= '0;
            r_skid       <= '0;
            r_ex_valid   <= 1'b0;
            r_skid_valid <= 1'b0;
            r_if_ready   <= 1'b1;
        end else if (flush) begin
            r_ex_valid   <= 1'b0;
            r_skid_valid <= 1'b0;
            r_if_ready   <= 1'b1;
        end else begin
            if (w_out_free) begin
                if (r_skid_valid) begin
                    r_out      <= r_skid;
                    r_ex_valid <= 1'b1;
                end else if (w_accept) begin
                    r_out      <= w_dec;
                    r_ex_valid <= 1'b1;
                end else begin
                    r_ex_valid <= 1'b0;
                end
            end else if (w_accept) begin
                r_skid <= w_dec;
            end
            r_skid_valid <= w_skid_valid_next;
            r_if_ready   <= ~w_skid_valid_next;
        end
    end

    assign if_ready   = r_if_ready;
    assign ex_valid   = r_ex_valid;
    assign opcode     = r_out.opcode;
    assign rd         = r_out.rd;
    assign funct3     = r_out.funct3;
    assign rs1_addr   = r_out.rs1_addr;
    assign rs2_addr   = r_out.rs2_addr;
    assign funct7     = r_out.funct7;
    assign imm        = r_out.imm;
    assign instr_type = r_out.instr_type;
    assign pc         = r_out.pc;
    assign rs1_data   = r_out.rs1_data;
    assign rs2_data   = r_out.rs2_data;
`ifdef DECODE_ILLEGAL_TRAP_EN
    assign ex_illegal = r_out.illegal;
`endif

endmodule
`default_nettype wire
